// File: rtl/seg_scan_drv.sv
// Six-digit 7-segment scan driver: sequential double-dabble BCD conversion of a
// clamped 20-bit value, leading-zero blanking with sign/DP, one-hot digit scan.
module seg_scan_drv #(
    parameter logic [15:0] CNT_MAX = 16'd49_999,
    parameter logic [19:0] NUM_SAT = 20'd999_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        sign,
    input  logic        seg_en,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } conv_state_t;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
    function automatic logic [23:0] dabble_adj(input logic [23:0] bcd);
        logic [23:0] r;
        r = bcd;
        for (int i = 0; i < 6; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Active-low {dp,g,f,e,d,c,b,a} pattern for one decimal digit.
    function automatic logic [7:0] digit_code(input logic [3:0] d);
        case (d)
            4'd0:    digit_code = 8'hC0;
            4'd1:    digit_code = 8'hF9;
            4'd2:    digit_code = 8'hA4;
            4'd3:    digit_code = 8'hB0;
            4'd4:    digit_code = 8'h99;
            4'd5:    digit_code = 8'h92;
            4'd6:    digit_code = 8'h82;
            4'd7:    digit_code = 8'hF8;
            4'd8:    digit_code = 8'h80;
            4'd9:    digit_code = 8'h90;
            default: digit_code = 8'hFF;
        endcase
    endfunction

    conv_state_t state_r;
    logic [19:0] data_sat_s;
    logic [19:0] bin_r;
    logic [19:0] conv_val_r;
    logic [19:0] last_r;
    logic [23:0] scratch_r;
    logic [23:0] adj_s;
    logic [23:0] bcd_r;
    logic [4:0]  bit_cnt_r;
    logic        pend_r;
    logic [15:0] cnt_r;
    logic [2:0]  idx_r;
    logic [2:0]  width_s;
    logic [3:0]  cur_digit_s;
    logic [7:0]  code_s;

    assign data_sat_s = (data > NUM_SAT) ? NUM_SAT : data;
    assign adj_s      = dabble_adj(scratch_r);

    // Converter FSM: capture on change/pending, 20 shift-add steps, then publish.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r    <= IDLE;
            bin_r      <= 20'd0;
            conv_val_r <= 20'd0;
            last_r     <= 20'd0;
            scratch_r  <= 24'd0;
            bcd_r      <= 24'd0;
            bit_cnt_r  <= 5'd0;
            pend_r     <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pend_r || (data_sat_s != last_r)) begin
                        conv_val_r <= data_sat_s;
                        bin_r      <= data_sat_s;
                        scratch_r  <= 24'd0;
                        bit_cnt_r  <= 5'd0;
                        state_r    <= SHIFT;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                SHIFT: begin
                    scratch_r <= {adj_s[22:0], bin_r[19]};
                    bin_r     <= {bin_r[18:0], 1'b0};
                    bit_cnt_r <= bit_cnt_r + 5'd1;
                    if (bit_cnt_r == 5'd19) begin
                        state_r <= LOAD;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                LOAD: begin
                    bcd_r   <= scratch_r;
                    last_r  <= conv_val_r;
                    pend_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Significant width and the digit under the scan index.
    always_comb begin
        width_s     = 3'd0;
        cur_digit_s = 4'd0;
        for (int k = 0; k < 6; k++) begin
            if ((bcd_r[4*k +: 4] != 4'd0) || point[k]) begin
                width_s = 3'(k);
            end else begin
                width_s = width_s;
            end
            if (idx_r == 3'(k)) begin
                cur_digit_s = bcd_r[4*k +: 4];
            end else begin
                cur_digit_s = cur_digit_s;
            end
        end
    end

    // Segment code for the current slot: blanking, minus sign, then decimal point.
    always_comb begin
        code_s = 8'hFF;
        if (idx_r > width_s) begin
            if (sign && (width_s < 3'd5) && (idx_r == width_s + 3'd1)) begin
                code_s = 8'hBF;
            end else begin
                code_s = 8'hFF;
            end
        end else begin
            code_s = digit_code(cur_digit_s);
        end
        if (point[idx_r]) begin
            code_s[7] = 1'b0;
        end else begin
            code_s[7] = code_s[7];
        end
    end

    // Dwell counter, digit index and registered select/segment outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_r <= 16'd0;
            idx_r <= 3'd0;
            sel   <= 6'b000000;
            seg   <= 8'hFF;
        end else if (!seg_en) begin
            cnt_r <= 16'd0;
            idx_r <= 3'd0;
            sel   <= 6'b000000;
            seg   <= 8'hFF;
        end else begin
            sel <= 6'd1 << idx_r;
            seg <= code_s;
            if (cnt_r == CNT_MAX) begin
                cnt_r <= 16'd0;
                idx_r <= (idx_r == 3'd5) ? 3'd0 : idx_r + 3'd1;
            end else begin
                cnt_r <= cnt_r + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Self-checking bench for seg_scan_drv: directed scenarios plus random values,
// checked against a decimal-arithmetic display model and a dwell-time scan model.
module tb_seg_scan_drv;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [19:0] data    = 20'd0;
    logic [5:0]  point   = 6'd0;
    logic        sign    = 1'b0;
    logic        seg_en  = 1'b0;
    logic [5:0]  sel;
    logic [7:0]  seg;

    int n_tests = 0;
    int n_fail  = 0;
    int scan_n  = 0;

    seg_scan_drv #(.CNT_MAX(16'd9)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .data    (data),
        .point   (point),
        .sign    (sign),
        .seg_en  (seg_en),
        .sel     (sel),
        .seg     (seg)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (scan step %0d)", tag, got, exp, scan_n);
        end
    endtask

    function automatic logic [7:0] pattern(input int d);
        case (d)
            0: pattern = 8'hC0;
            1: pattern = 8'hF9;
            2: pattern = 8'hA4;
            3: pattern = 8'hB0;
            4: pattern = 8'h99;
            5: pattern = 8'h92;
            6: pattern = 8'h82;
            7: pattern = 8'hF8;
            8: pattern = 8'h80;
            9: pattern = 8'h90;
            default: pattern = 8'hFF;
        endcase
    endfunction

    // Expected code of digit k for value v, computed with decimal arithmetic.
    function automatic logic [7:0] model_seg(input int v, input logic [5:0] p, input logic s, input int k);
        int dig[6];
        int x;
        int w;
        logic [7:0] r;
        x = (v > 999999) ? 999999 : v;
        for (int i = 0; i < 6; i++) begin
            dig[i] = x % 10;
            x = x / 10;
        end
        w = 0;
        for (int i = 0; i < 6; i++) begin
            if (dig[i] != 0 || p[i]) w = i;
        end
        if (k > w) r = (s && w < 5 && k == w + 1) ? 8'hBF : 8'hFF;
        else       r = pattern(dig[k]);
        if (p[k]) r[7] = 1'b0;
        return r;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One scan cycle: digit index advances every 10 cycles since enable.
    task automatic step_scan(input int val, input bit chk_seg);
        int idx;
        logic [5:0] exp_sel;
        tick();
        idx     = (scan_n / 10) % 6;
        exp_sel = 6'd1 << idx;
        check_eq("sel", {26'd0, sel}, {26'd0, exp_sel});
        if (chk_seg) check_eq("seg", {24'd0, seg}, {24'd0, model_seg(val, point, sign, idx)});
        scan_n++;
    endtask

    task automatic run_scan(input int ncyc, input int val);
        for (int i = 0; i < ncyc; i++) step_scan(val, 1'b1);
    endtask

    task automatic settle();
        seg_en = 1'b0;
        repeat (50) tick();
        check_eq("off_sel", {26'd0, sel}, 32'd0);
        check_eq("off_seg", {24'd0, seg}, 32'hFF);
    endtask

    task automatic start_scan();
        seg_en = 1'b1;
        scan_n = 0;
    endtask

    initial begin
        int val;

        // Reset state
        repeat (3) tick();
        check_eq("rst_sel", {26'd0, sel}, 32'd0);
        check_eq("rst_seg", {24'd0, seg}, 32'hFF);
        sys_rst = 1'b0;

        // Basic scan of 123456 with wrap-around
        data = 20'd123456; point = 6'd0; sign = 1'b0;
        settle();
        start_scan();
        run_scan(70, 123456);

        // Point/sign/blanking, then drop seg_en at index 3 and re-enable
        data = 20'd5; point = 6'b000100; sign = 1'b1;
        settle();
        start_scan();
        run_scan(34, 5);
        seg_en = 1'b0;
        tick();
        check_eq("drop_sel", {26'd0, sel}, 32'd0);
        check_eq("drop_seg", {24'd0, seg}, 32'hFF);
        tick();
        check_eq("drop_sel2", {26'd0, sel}, 32'd0);
        start_scan();
        run_scan(15, 5);

        // Clamp with sign ignored
        data = 20'hFFFFF; point = 6'd0; sign = 1'b1;
        settle();
        start_scan();
        run_scan(65, 1048575);

        // Data change right after a conversion starts
        data = 20'd7; point = 6'd0; sign = 1'b0;
        settle();
        data = 20'd42;
        start_scan();
        step_scan(7, 1'b1);
        step_scan(7, 1'b1);
        data = 20'd43;
        repeat (18) step_scan(7, 1'b1);
        repeat (3)  step_scan(0, 1'b0);
        repeat (18) step_scan(42, 1'b1);
        repeat (4)  step_scan(0, 1'b0);
        repeat (36) step_scan(43, 1'b1);

        // Reset during SHIFT, then reconversion of the current data
        data = 20'd654321;
        tick();
        tick();
        sys_rst = 1'b1;
        #1;
        check_eq("mid_rst_sel", {26'd0, sel}, 32'd0);
        check_eq("mid_rst_seg", {24'd0, seg}, 32'hFF);
        tick();
        check_eq("mid_rst_seg2", {24'd0, seg}, 32'hFF);
        sys_rst = 1'b0;
        scan_n = 0;
        repeat (24) step_scan(0, 1'b0);
        repeat (40) step_scan(654321, 1'b1);

        // Random values, with point/sign changed while scanning
        for (int it = 0; it < 6; it++) begin
            case (it % 3)
                0:       val = int'($urandom_range(0, 999));
                1:       val = int'($urandom_range(0, 999999));
                default: val = int'($urandom_range(0, 1048575));
            endcase
            data  = val[19:0];
            point = 6'($urandom_range(0, 63) & $urandom_range(0, 63));
            sign  = 1'($urandom_range(0, 1));
            settle();
            start_scan();
            for (int i = 0; i < 65; i++) begin
                if (i % 13 == 7) begin
                    point = 6'($urandom_range(0, 63) & $urandom_range(0, 63));
                    sign  = 1'($urandom_range(0, 1));
                end
                step_scan(val, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
